// File: rtl/if_id_reg.sv
// F-to-D pipeline register: holds the fetched instruction/PC under stall, injects a bubble on flush.
// Optional stall-cycle counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic [5:0]  d_opcode,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [4:0]  d_rd,
  output logic [4:0]  d_shamt,
  output logic [5:0]  d_funct,
  output logic [15:0] d_imm16,
  output logic [25:0] d_imm26,
  output logic [15:0] d_stall_cnt
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // Stall outranks flush: a flush raised during a stall is dropped, not deferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_instr <= NOP_INSTR;
        r_pc    <= RESET_PC;
        r_valid <= 1'b0;
      end else begin
        r_instr <= f_instr;
        r_pc    <= f_pc;
        r_valid <= 1'b1;
      end
    end
  end

  assign d_instr  = r_instr;
  assign d_pc     = r_pc;
  assign d_valid  = r_valid;
  assign d_pc8    = r_pc + 32'd8;

  assign d_opcode = r_instr[31:26];
  assign d_rs     = r_instr[25:21];
  assign d_rt     = r_instr[20:16];
  assign d_rd     = r_instr[15:11];
  assign d_shamt  = r_instr[10:6];
  assign d_funct  = r_instr[5:0];
  assign d_imm16  = r_instr[15:0];
  assign d_imm26  = r_instr[25:0];

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign d_stall_cnt = r_stall_cnt;
`else
  assign d_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vector table, random run against a reference model,
// async reset and (with IF_ID_STALL_CNT_EN) counter saturation.
module tb_if_id_reg;

`ifdef IF_ID_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_instr, f_pc;
  logic        stall, flush;
  logic [31:0] d_instr, d_pc, d_pc8;
  logic        d_valid;
  logic [5:0]  d_opcode, d_funct;
  logic [4:0]  d_rs, d_rt, d_rd, d_shamt;
  logic [15:0] d_imm16, d_stall_cnt;
  logic [25:0] d_imm26;

  if_id_reg #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .f_instr(f_instr), .f_pc(f_pc),
    .stall(stall), .flush(flush),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8), .d_valid(d_valid),
    .d_opcode(d_opcode), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .d_shamt(d_shamt), .d_funct(d_funct), .d_imm16(d_imm16),
    .d_imm26(d_imm26), .d_stall_cnt(d_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the D stage should hold.
  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  logic [15:0] m_cnt;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev, input logic [15:0] ecnt);
    chk({tag, ".d_instr"}, d_instr, ei);
    chk({tag, ".d_pc"},    d_pc, ep);
    chk({tag, ".d_pc8"},   d_pc8, ep + 32'd8);
    chk({tag, ".d_valid"}, 32'(d_valid), 32'(ev));
    chk({tag, ".d_opcode"}, 32'(d_opcode), ei >> 26);
    chk({tag, ".d_rs"},    32'(d_rs),    (ei >> 21) & 32'h1F);
    chk({tag, ".d_rt"},    32'(d_rt),    (ei >> 16) & 32'h1F);
    chk({tag, ".d_rd"},    32'(d_rd),    (ei >> 11) & 32'h1F);
    chk({tag, ".d_shamt"}, 32'(d_shamt), (ei >> 6) & 32'h1F);
    chk({tag, ".d_funct"}, 32'(d_funct), ei & 32'h3F);
    chk({tag, ".d_imm16"}, 32'(d_imm16), ei & 32'hFFFF);
    chk({tag, ".d_imm26"}, 32'(d_imm26), ei & 32'h03FF_FFFF);
    chk({tag, ".d_stall_cnt"}, 32'(d_stall_cnt), CNT_EN ? 32'(ecnt) : 32'd0);
  endtask

  task automatic model_reset();
    m_instr = NOP_INSTR;
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_cnt   = 16'd0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic [31:0] fi, input logic [31:0] fp);
    if (s) begin
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (f) begin
      m_instr = NOP_INSTR;
      m_pc    = RESET_PC;
      m_valid = 1'b0;
    end else begin
      m_instr = fi;
      m_pc    = fp;
      m_valid = 1'b1;
    end
  endtask

  // Drive, clock, then check against the model away from the edge.
  task automatic cycle(input string tag, input logic s, input logic f,
                       input logic [31:0] fi, input logic [31:0] fp);
    stall = s; flush = f; f_instr = fi; f_pc = fp;
    @(posedge clk);
    model_edge(s, f, fi, fp);
    #1;
    check_all(tag, m_instr, m_pc, m_valid, m_cnt);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h3C01_1234, 32'h0000_3000, 32'h3C01_1234, 32'h0000_3000, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h2022_FFFF, 32'h0000_3004, 32'h2022_FFFF, 32'h0000_3004, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h1111_1111, 32'h0000_3008, 32'h2022_FFFF, 32'h0000_3004, 1'b1, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'h2222_2222, 32'h0000_300C, 32'h2022_FFFF, 32'h0000_3004, 1'b1, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h3333_3333, 32'h0000_3010, 32'h2022_FFFF, 32'h0000_3004, 1'b1, 16'd3};
    vecs[5]  = '{1'b0, 1'b1, 32'h4444_4444, 32'h0000_3014, 32'h0000_0000, 32'h0000_3000, 1'b0, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'h8C43_0004, 32'h0000_3018, 32'h8C43_0004, 32'h0000_3018, 1'b1, 16'd3};
    vecs[7]  = '{1'b1, 1'b1, 32'h5555_5555, 32'h0000_301C, 32'h8C43_0004, 32'h0000_3018, 1'b1, 16'd4};
    vecs[8]  = '{1'b0, 1'b1, 32'h6666_6666, 32'h0000_3020, 32'h0000_0000, 32'h0000_3000, 1'b0, 16'd4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0C00_0C00, 32'hFFFF_FFFC, 32'h0C00_0C00, 32'hFFFF_FFFC, 1'b1, 16'd4};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_3001, 32'h0000_0001, 32'h0000_3001, 1'b1, 16'd4};

    reset = 1'b1; stall = 1'b0; flush = 1'b0; f_instr = '0; f_pc = '0;
    model_reset();
    #2;
    check_all("reset", NOP_INSTR, RESET_PC, 1'b0, 16'd0);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush;
      f_instr = vecs[i].instr; f_pc = vecs[i].pc;
      @(posedge clk);
      model_edge(vecs[i].stall, vecs[i].flush, vecs[i].instr, vecs[i].pc);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
                vecs[i].exp_valid, vecs[i].exp_cnt);
      if (i == 0) begin
        chk("first.opcode", 32'(d_opcode), 32'h0F);
        chk("first.rt",     32'(d_rt),     32'd1);
        chk("first.imm16",  32'(d_imm16),  32'h1234);
        chk("first.pc8",    d_pc8,         32'h0000_3008);
      end
      if (i == 9) chk("wrap.pc8", d_pc8, 32'h0000_0004);
    end

    for (int i = 0; i < 300; i++) begin
      cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom, $urandom);
    end

    // Async reset mid-cycle while D holds valid data.
    cycle("preload", 1'b0, 1'b0, 32'hAC85_0010, 32'h0000_4000);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst", NOP_INSTR, RESET_PC, 1'b0, 16'd0);

    // Release mid-cycle with stall high: first edge must still hold the bubble.
    @(negedge clk);
    reset = 1'b0;
    cycle("rel_stall", 1'b1, 1'b0, 32'h1234_5678, 32'h0000_5000);
    chk("rel_stall.valid", 32'(d_valid), 32'd0);
    cycle("rel_load", 1'b0, 1'b0, 32'h2408_0005, 32'h0000_5004);
    chk("rel_load.instr", d_instr, 32'h2408_0005);

`ifdef IF_ID_STALL_CNT_EN
    stall = 1'b1; flush = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_edge(1'b1, 1'b0, f_instr, f_pc);
    end
    #1;
    chk("sat.cnt", 32'(d_stall_cnt), 32'h0000_FFFF);
    check_all("sat", m_instr, m_pc, m_valid, m_cnt);
    cycle("sat_flush", 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_6000);
    chk("sat_flush.cnt", 32'(d_stall_cnt), 32'h0000_FFFF);
    #2;
    reset = 1'b1;
    #1;
    chk("sat_rst.cnt", 32'(d_stall_cnt), 32'd0);
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- F-to-D pipeline register of the P6 five-stage MIPS core.
- Captures the fetched instruction and PC, and holds them under stall.
- Inserts a bubble on flush.
- Splits the held instruction into decode fields. d_imm16 is the 16-bit immediate fed to the D-stage immediate extender; the other fields feed the D-stage controller and GRF read ports.

Parameters:
- RESET_PC, 32'h0000_3000, PC value presented on d_pc after reset and in bubbles.
- NOP_INSTR, 32'h0000_0000, instruction word written on reset and on flush (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- f_instr  input  32  instruction word from IM for the current F-stage PC
- f_pc  input  32  F-stage PC
- stall  input  1  hazard unit hold request; D contents are frozen
- flush  input  1  replace D contents with a bubble at next edge
- d_instr  output  32  registered instruction
- d_pc  output  32  registered PC
- d_pc8  output  32  d_pc + 8 (jal/jalr link value)
- d_valid  output  1  1 = real instruction, 0 = bubble
- d_opcode  output  6  d_instr[31:26]
- d_rs  output  5  d_instr[25:21]
- d_rt  output  5  d_instr[20:16]
- d_rd  output  5  d_instr[15:11]
- d_shamt  output  5  d_instr[10:6]
- d_funct  output  6  d_instr[5:0]
- d_imm16  output  16  d_instr[15:0], to immediate extender
- d_imm26  output  26  d_instr[25:0], jump target field
- d_stall_cnt  output  16  stall-cycle counter (only with the optional feature)

Behaviour:
- Reset: asynchronous and active-high; takes effect immediately, independent of clk.
  - d_instr = NOP_INSTR, d_pc = RESET_PC, d_valid = 0.
  - d_stall_cnt = 0.
  - All field outputs follow from NOP_INSTR, i.e. all zero.
- Latency: one cycle. An instruction presented on f_instr/f_pc at edge N is visible on the D outputs after edge N.
- Per rising edge, priority order reset > stall > flush > load:
  - stall=1: d_instr, d_pc and d_valid hold. A flush asserted in the same cycle is ignored; the hazard unit must reassert it once stall drops.
  - stall=0, flush=1: d_instr = NOP_INSTR, d_pc = RESET_PC, d_valid = 0.
  - stall=0, flush=0: d_instr = f_instr, d_pc = f_pc, d_valid = 1.
- Field outputs are purely combinational slices of the d_instr register, with zero added delay.
- d_pc8 = d_pc + 32'd8, modulo 2^32.
  - Wrap: d_pc = 32'hFFFF_FFFC gives d_pc8 = 32'h0000_0004.
  - No overflow flag.
- f_pc is not checked for alignment; misaligned values pass through unchanged.
- A stall held for any number of cycles keeps all outputs stable with no glitches. Outputs change only on a clk edge or on reset.
- Reset deasserted mid-cycle: the first load happens at the next rising edge with reset low. The hold-versus-load decision on that edge still honours stall and flush.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN
- Defined:
  - d_stall_cnt increments by 1 on every rising edge where stall=1 and reset=0.
  - It saturates at 16'hFFFF and never wraps.
  - It clears only on reset.
  - Flush does not affect it.
- Undefined:
  - The counter register is not built.
  - d_stall_cnt is tied to 16'h0000.
  - The port stays present so instantiations are identical in both builds.

Test Plan:
- Reset, then release with stall=0, flush=0, f_instr=32'h3C01_1234, f_pc=32'h3000:
  - During reset, outputs are 0 / RESET_PC with d_valid=0.
  - After the first edge: d_instr=32'h3C01_1234, d_opcode=6'h0F, d_rt=5'd1, d_imm16=16'h1234, d_pc8=32'h3008, d_valid=1.
- Load 32'h2022_FFFF at PC 32'h3004, then assert stall for 3 edges while f_instr changes each cycle:
  - d_instr stays 32'h2022_FFFF and d_pc stays 32'h3004.
  - With IF_ID_STALL_CNT_EN, d_stall_cnt=3.
- flush=1, stall=0, with a valid instruction in D: after the edge, d_instr=0, d_pc=32'h3000, d_valid=0.
- stall=1 and flush=1 in the same cycle: D holds its prior contents and d_valid stays 1. Then stall=0, flush=1: bubble inserted.
- f_pc=32'hFFFF_FFFC loaded: d_pc8=32'h0000_0004.
- Assert reset asynchronously between edges while D holds valid data:
  - Outputs go to NOP_INSTR / RESET_PC / d_valid=0 before the next edge.
  - d_stall_cnt=0.
  - With the feature, hold stall for 65540 cycles to confirm the counter saturates at 16'hFFFF.
